// File: rtl/addsub_accum_pipe.sv
// Pipelined add/subtract unit with carry-in, internal accumulator and sticky
// signed-overflow flag; input and output register stages are optional.
module addsub_accum_pipe #(
  parameter int WIDTH   = 18,
  parameter int IN_REG  = 1,
  parameter int OUT_REG = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             cin,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] OUT,
  output logic             cout,
  output logic             ovf
);

  // Handshake: in_valid qualifies IN1/IN2/cin/mode/acc_clr on any CE-enabled
  // edge; there is no ready, the unit accepts one operation per enabled edge.
  // out_valid marks the single cycle on which OUT/cout/ovf carry that result.

  logic             a_valid;
  logic [WIDTH-1:0] a_in1;
  logic [WIDTH-1:0] a_in2;
  logic             a_cin;
  logic [1:0]       a_mode;
  logic             a_clr;

  logic [WIDTH-1:0] r;
  logic             cout_r;
  logic             ovf_r;
  logic             valid_r;

  logic [WIDTH-1:0] x;
  logic [WIDTH:0]   sum;
  logic             s_ovf;

  generate
    if (IN_REG != 0) begin : g_in_reg
      always_ff @(posedge CLK) begin
        if (RST) begin
          a_valid <= 1'b0;
          a_in1   <= '0;
          a_in2   <= '0;
          a_cin   <= 1'b0;
          a_mode  <= 2'b00;
          a_clr   <= 1'b0;
        end else if (CE) begin
          a_valid <= in_valid;
          a_in1   <= IN1;
          a_in2   <= IN2;
          a_cin   <= cin;
          a_mode  <= mode;
          a_clr   <= acc_clr;
        end
      end
    end else begin : g_in_pass
      assign a_valid = in_valid;
      assign a_in1   = IN1;
      assign a_in2   = IN2;
      assign a_cin   = cin;
      assign a_mode  = mode;
      assign a_clr   = acc_clr;
    end
  endgenerate

  // Accumulate mode takes X from R, or from zero when clearing in the same op.
  always_comb begin
    x     = a_in1;
    sum   = '0;
    s_ovf = 1'b0;
    if (a_mode[1]) begin
      x = a_clr ? '0 : r;
    end
    if (a_mode[0]) begin
      sum   = {1'b0, x} - {1'b0, a_in2} - {{WIDTH{1'b0}}, a_cin};
      s_ovf = (x[WIDTH-1] != a_in2[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end else begin
      sum   = {1'b0, x} + {1'b0, a_in2} + {{WIDTH{1'b0}}, a_cin};
      s_ovf = (x[WIDTH-1] == a_in2[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end
  end

  // A standalone clear (no valid) zeroes R and the sticky flag but keeps cout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r       <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (CE) begin
      valid_r <= a_valid;
      ovf_r   <= (ovf_r & ~a_clr) | (a_valid & s_ovf);
      if (a_valid) begin
        r      <= sum[WIDTH-1:0];
        cout_r <= sum[WIDTH];
      end else if (a_clr) begin
        r <= '0;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge CLK) begin
        if (RST) begin
          out_valid <= 1'b0;
          OUT       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (CE) begin
          out_valid <= valid_r;
          OUT       <= r;
          cout      <= cout_r;
          ovf       <= ovf_r;
        end
      end
    end else begin : g_out_pass
      assign out_valid = valid_r;
      assign OUT       = r;
      assign cout      = cout_r;
      assign ovf       = ovf_r;
    end
  endgenerate

endmodule

// File: tb/tb_addsub_accum_pipe.sv
// Bench for addsub_accum_pipe: four parameter variants share one stimulus
// stream and are compared against a transaction-level reference model.
module tb_addsub_accum_pipe;

  localparam int     W = 18;
  localparam longint M = longint'(1) << W;
  localparam longint H = M / 2;

  // ---------------- clock / reset / inputs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, ce, in_valid, cin, acc_clr;
  logic [1:0]   mode;
  logic [W-1:0] in1, in2;

  // index g: IN_REG = g/2, OUT_REG = g%2; g=3 is the default configuration
  wire [3:0]   ov;
  wire [3:0]   co;
  wire [3:0]   of;
  wire [W-1:0] o [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    addsub_accum_pipe #(.WIDTH(W), .IN_REG(g / 2), .OUT_REG(g % 2)) dut (
      .CLK      (clk),
      .RST      (rst),
      .CE       (ce),
      .in_valid (in_valid),
      .IN1      (in1),
      .IN2      (in2),
      .cin      (cin),
      .mode     (mode),
      .acc_clr  (acc_clr),
      .out_valid(ov[g]),
      .OUT      (o[g]),
      .cout     (co[g]),
      .ovf      (of[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] got=%0h exp=%0h at %0t", nm, g, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Operations are applied in order of CE-enabled edges; an output reflects
  // the state reached IN_REG+OUT_REG enabled edges earlier.
  typedef struct {
    logic [W-1:0] acc;
    logic         c;
    logic         ov;
    logic         v;
  } snap_t;

  snap_t        hist[$];
  logic [W-1:0] m_acc;
  logic         m_c, m_ov;
  bit           model_on = 1'b0;
  longint       mx, my, sx, sy, mr, sr, ms, mci;
  bit           mc, movf;

  always @(posedge clk) begin
    if (rst) begin
      m_acc = '0;
      m_c   = 1'b0;
      m_ov  = 1'b0;
      hist.delete();
      model_on = 1'b1;
    end else if (ce) begin
      mci = longint'(cin);
      mx  = mode[1] ? (acc_clr ? 64'sd0 : longint'(m_acc)) : longint'(in1);
      my  = longint'(in2);
      sx  = (mx >= H) ? mx - M : mx;
      sy  = (my >= H) ? my - M : my;
      if (mode[0]) begin
        mr = mx - my - mci;
        sr = sx - sy - mci;
        mc = (mr < 0);
      end else begin
        mr = mx + my + mci;
        sr = sx + sy + mci;
        mc = (mr >= M);
      end
      ms   = ((mr % M) + M) % M;
      movf = (sr >= H) || (sr < -H);
      if (in_valid) begin
        m_acc = W'(ms);
        m_c   = mc;
      end else if (acc_clr) begin
        m_acc = '0;
      end
      m_ov = (m_ov && !acc_clr) || (in_valid && movf);
      hist.push_back('{m_acc, m_c, m_ov, in_valid});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  function automatic snap_t exp_for(int d);
    snap_t z;
    z = '{'0, 1'b0, 1'b0, 1'b0};
    if (hist.size() > d) z = hist[hist.size() - 1 - d];
    return z;
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      for (int g = 0; g < 4; g++) begin
        snap_t e;
        e = exp_for(g / 2 + g % 2);
        check("mdl_valid", g, 32'(ov[g]), 32'(e.v));
        check("mdl_out",   g, 32'(o[g]),  32'(e.acc));
        check("mdl_cout",  g, 32'(co[g]), 32'(e.c));
        check("mdl_ovf",   g, 32'(of[g]), 32'(e.ov));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    ce = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; mode = 2'b00;
    cin = 1'b0; in1 = '0; in2 = '0;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [1:0] md, input logic clr);
    ce = 1'b1; in_valid = 1'b1; in1 = a; in2 = b; cin = ci; mode = md; acc_clr = clr;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(H - 1);
      3:       return W'(H);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] a, b;
    logic         ci;
    logic [1:0]   md;
    logic         clr;
    logic [W-1:0] e_out;
    logic         e_c, e_ov;
  } vec_t;

  localparam int N = 10;
  vec_t vt[N];

  int lat[4];
  int pulses[4];
  logic exp_ce[8];

  initial begin
    vt[0] = '{18'd5,       18'd7,   1'b1, 2'b00, 1'b0, 18'd13,      1'b0, 1'b0};
    vt[1] = '{18'h3FFFF,   18'h1,   1'b0, 2'b00, 1'b0, 18'h00000,   1'b1, 1'b0};
    vt[2] = '{18'd3,       18'd5,   1'b0, 2'b01, 1'b0, 18'h3FFFE,   1'b1, 1'b0};
    vt[3] = '{18'd777,     18'd10,  1'b0, 2'b10, 1'b1, 18'd10,      1'b0, 1'b0};
    vt[4] = '{18'd777,     18'd20,  1'b0, 2'b10, 1'b0, 18'd30,      1'b0, 1'b0};
    vt[5] = '{18'd777,     18'd30,  1'b0, 2'b10, 1'b0, 18'd60,      1'b0, 1'b0};
    vt[6] = '{18'd777,     18'd40,  1'b0, 2'b10, 1'b0, 18'd100,     1'b0, 1'b0};
    vt[7] = '{18'd777,     18'd100, 1'b0, 2'b11, 1'b0, 18'd0,       1'b0, 1'b0};
    vt[8] = '{18'h1FFFF,   18'h1,   1'b0, 2'b00, 1'b0, 18'h20000,   1'b0, 1'b1};
    vt[9] = '{18'd1,       18'd1,   1'b0, 2'b00, 1'b0, 18'd2,       1'b0, 1'b1};

    // Reset with CE low and junk on the inputs: everything must still clear.
    rst = 1'b1; ce = 1'b0; in_valid = 1'b1; in1 = '1; in2 = '1;
    cin = 1'b1; mode = 2'b11; acc_clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_valid", g, 32'(ov[g]), 32'd0);
      check("rst_out",   g, 32'(o[g]),  32'd0);
      check("rst_cout",  g, 32'(co[g]), 32'd0);
      check("rst_ovf",   g, 32'(of[g]), 32'd0);
    end
    rst = 1'b0;
    idle();

    // Back-to-back table: result of vt[j] is visible three cycles after it.
    for (int j = 0; j < N + 3; j++) begin
      if (j >= 3) begin
        check("tbl_valid", 3, 32'(ov[3]), 32'd1);
        check("tbl_out",   3, 32'(o[3]),  32'(vt[j-3].e_out));
        check("tbl_cout",  3, 32'(co[3]), 32'(vt[j-3].e_c));
        check("tbl_ovf",   3, 32'(of[3]), 32'(vt[j-3].e_ov));
      end else begin
        check("tbl_lead", 3, 32'(ov[3]), 32'd0);
      end
      if (j < N) drive(vt[j].a, vt[j].b, vt[j].ci, vt[j].md, vt[j].clr);
      else       idle();
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);

    // Standalone clear drops the sticky flag; next result shows ovf=0.
    check("pre_clr_ovf", 3, 32'(of[3]), 32'd1);
    in_valid = 1'b0; acc_clr = 1'b1;
    @(negedge clk);
    idle();
    drive(18'd1, 18'd1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    idle();
    begin
      int k;
      for (k = 0; k < 10; k++) begin
        if (ov[3]) break;
        @(negedge clk);
      end
      check("clr_timeout", 3, 32'(k < 10), 32'd1);
    end
    check("clr_out",  3, 32'(o[3]),  32'd2);
    check("clr_ovf",  3, 32'(of[3]), 32'd0);
    check("clr_cout", 3, 32'(co[3]), 32'd0);
    repeat (3) @(negedge clk);

    // CE stall: valid on cycles 0 and 2, CE low on cycle 3.
    exp_ce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      if (c >= 1) check("ce_valid", 3, 32'(ov[3]), 32'(exp_ce[c]));
      if (c == 3 || c == 4 || c == 5) check("ce_out_a", 3, 32'(o[3]), 32'd3);
      if (c == 6) check("ce_out_b", 3, 32'(o[3]), 32'd9);
      idle();
      if (c == 0) drive(18'd1, 18'd2, 1'b0, 2'b00, 1'b0);
      if (c == 2) drive(18'd4, 18'd5, 1'b0, 2'b00, 1'b0);
      if (c == 3) ce = 1'b0;
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);

    // Latency per configuration: single pulse, one out_valid each.
    for (int g = 0; g < 4; g++) begin
      lat[g] = 0;
      pulses[g] = 0;
    end
    drive(18'd7, 18'd8, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    idle();
    for (int c = 1; c < 8; c++) begin
      for (int g = 0; g < 4; g++) begin
        if (ov[g]) begin
          pulses[g]++;
          if (lat[g] == 0) lat[g] = c;
        end
      end
      @(negedge clk);
    end
    for (int g = 0; g < 4; g++) begin
      check("latency", g, 32'(lat[g]), 32'(1 + g / 2 + g % 2));
      check("pulses",  g, 32'(pulses[g]), 32'd1);
    end

    // Reset after three in-flight ops (CE low during reset).
    drive(18'd11, 18'd1, 1'b0, 2'b00, 1'b0); @(negedge clk);
    drive(18'd12, 18'd1, 1'b0, 2'b00, 1'b0); @(negedge clk);
    drive(18'd13, 18'd1, 1'b0, 2'b00, 1'b0); @(negedge clk);
    rst = 1'b1; ce = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) begin
      for (int g = 0; g < 4; g++) check("rst_fl_valid", g, 32'(ov[g]), 32'd0);
      check("rst_fl_out",  3, 32'(o[3]),  32'd0);
      check("rst_fl_cout", 3, 32'(co[3]), 32'd0);
      check("rst_fl_ovf",  3, 32'(of[3]), 32'd0);
      @(negedge clk);
    end

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      ce       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      mode     = 2'($urandom_range(0, 3));
      acc_clr  = ($urandom_range(0, 7) == 0);
      cin      = 1'($urandom_range(0, 1));
      in1      = rnd_op();
      in2      = rnd_op();
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
